// File: rtl/seq_mul_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
package seq_mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/mul_abs_neg.sv
// Conditional two's-complement negate: y = neg ? -x : x, wrapping modulo 2^W.
module mul_abs_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per clock, with
// valid/ready handshakes on operands and product; signed via magnitude + sign fix.
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  state_t             state_reg;
  logic [WIDTH-1:0]   ma_reg;
  logic [WIDTH-1:0]   mb_reg;
  logic               neg_reg;
  logic [2*WIDTH:0]   acc_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] product_reg;
  logic               out_valid_reg;
  logic               in_ready_reg;
  logic               busy_reg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     acc_hi;
  logic [2*WIDTH:0]   acc_step;
  logic [2*WIDTH-1:0] product_fixed;
  logic               last_iter;

  mul_abs_neg #(.W(WIDTH)) u_abs_a (
    .x   (a),
    .neg (signed_mode & a[WIDTH-1]),
    .y   (a_mag)
  );

  mul_abs_neg #(.W(WIDTH)) u_abs_b (
    .x   (b),
    .neg (signed_mode & b[WIDTH-1]),
    .y   (b_mag)
  );

  // Upper half is one bit wider than an operand so the add never overflows.
  assign acc_hi    = acc_reg[2*WIDTH:WIDTH] + {1'b0, (mb_reg[0] ? ma_reg : '0)};
  assign acc_step  = {acc_hi, acc_reg[WIDTH-1:0]} >> 1;
  assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

  // Sign fix applies to the value being produced on the final RUN edge.
  mul_abs_neg #(.W(2*WIDTH)) u_fix (
    .x   (acc_step[2*WIDTH-1:0]),
    .neg (neg_reg),
    .y   (product_fixed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      ma_reg        <= '0;
      mb_reg        <= '0;
      neg_reg       <= 1'b0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      product_reg   <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            ma_reg       <= a_mag;
            mb_reg       <= b_mag;
            neg_reg      <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_reg      <= '0;
            cnt_reg      <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          acc_reg <= acc_step;
          mb_reg  <= mb_reg >> 1;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (last_iter) begin
            product_reg   <= product_fixed;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign product   = product_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomised and directed checks of seq_multiplier at WIDTH=8 and WIDTH=16
// against an arithmetic reference model.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        signed_mode;
  logic [15:0] a_drv;
  logic [15:0] b_drv;
  int          w_sel;

  logic        ir8, ov8, busy8;
  logic [15:0] prod8;
  logic        ir16, ov16, busy16;
  logic [31:0] prod16;

  logic        ir, ov, busy;
  logic [31:0] prod;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid && (w_sel == 8)),
    .in_ready    (ir8),
    .a           (a_drv[7:0]),
    .b           (b_drv[7:0]),
    .signed_mode (signed_mode),
    .out_valid   (ov8),
    .out_ready   (out_ready),
    .product     (prod8),
    .busy        (busy8)
  );

  seq_multiplier #(.WIDTH(16)) u_dut16 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid && (w_sel == 16)),
    .in_ready    (ir16),
    .a           (a_drv),
    .b           (b_drv),
    .signed_mode (signed_mode),
    .out_valid   (ov16),
    .out_ready   (out_ready),
    .product     (prod16),
    .busy        (busy16)
  );

  always_comb begin
    ir   = (w_sel == 16) ? ir16   : ir8;
    ov   = (w_sel == 16) ? ov16   : ov8;
    busy = (w_sel == 16) ? busy16 : busy8;
    prod = (w_sel == 16) ? prod16 : {16'h0, prod8};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Plain integer multiply of the operands interpreted per mode, truncated to 2w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic sm);
    longint m, sa, sb, p;
    m  = (longint'(1) << w) - 1;
    sa = longint'(a) & m;
    sb = longint'(b) & m;
    if (sm && sa >= (longint'(1) << (w - 1))) sa -= longint'(1) << w;
    if (sm && sb >= (longint'(1) << (w - 1))) sb -= longint'(1) << w;
    p = sa * sb;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic sm, input int stall);
    int          cnt;
    bit          bad;
    logic [31:0] exp_p;
    logic [31:0] held;
    w_sel = w;
    cnt = 0;
    while (!ir && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    check("idle_in_ready", 64'(ir), 64'd1);
    a_drv = a;
    b_drv = b;
    signed_mode = sm;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    exp_p = ref_mul(w, a, b, sm);
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_ready_busy", 64'({ir, busy}), 64'b01);
    cnt = 0;
    bad = 0;
    while (!ov && cnt < 100) begin
      a_drv = 16'($urandom);
      b_drv = 16'($urandom);
      signed_mode = 1'($urandom);
      if (ir || !busy) bad = 1;
      @(negedge clk);
      cnt++;
    end
    check("latency", 64'(cnt), 64'(w));
    check("run_in_ready", 64'(bad), 64'd0);
    check("product", 64'(prod), 64'(exp_p));
    held = prod;
    bad = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!ov || prod !== held || ir || !busy) bad = 1;
    end
    if (stall > 0) check("stall_stable", 64'(bad), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("handshake_ov_ir_busy", 64'({ov, ir, busy}), 64'b010);
    $display("[TB] w=%0d a=%0h b=%0h signed=%0d stall=%0d -> product=%0h (exp %0h)",
             w, a, b, sm, stall, held, exp_p);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    signed_mode = 1'b0;
    a_drv = '0;
    b_drv = '0;
    w_sel = 8;
    repeat (2) @(negedge clk);
    check("reset8_ir_ov_busy", 64'({ir8, ov8, busy8}), 64'b100);
    check("reset8_product", 64'(prod8), 64'd0);
    check("reset16_ir_ov_busy", 64'({ir16, ov16, busy16}), 64'b100);
    check("reset16_product", 64'(prod16), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8, 16'h00FF, 16'h00FF, 1'b0, 0);
    run_op(8, 16'h00FD, 16'h0007, 1'b1, 0);
    run_op(8, 16'h0080, 16'h0080, 1'b1, 0);
    run_op(8, 16'h0080, 16'h0080, 1'b0, 0);
    run_op(8, 16'h0080, 16'h0001, 1'b1, 0);
    run_op(8, 16'h0000, 16'h00FF, 1'b1, 0);
    run_op(8, 16'h0012, 16'h0034, 1'b0, 5);

    // Reset in the middle of RUN discards the operation.
    w_sel = 8;
    a_drv = 16'h0077;
    b_drv = 16'h0055;
    signed_mode = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_reset_ir_ov_busy", 64'({ir8, ov8, busy8}), 64'b100);
    check("midrun_reset_product", 64'(prod8), 64'd0);
    $display("[TB] reset during RUN -> ir=%0d ov=%0d busy=%0d product=%0h", ir8, ov8, busy8, prod8);
    run_op(8, 16'h0003, 16'h0005, 1'b0, 0);

    run_op(16, 16'hFFFF, 16'h0002, 1'b0, 0);
    run_op(16, 16'hFFFF, 16'h0002, 1'b1, 0);
    run_op(16, 16'h8000, 16'h8000, 1'b1, 2);
    run_op(16, 16'hFFFF, 16'hFFFF, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(($urandom_range(0, 1) == 1) ? 16 : 8, 16'($urandom), 16'($urandom),
             1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
